reg_view_scan: RTL and testbench



---
 rtl/reg_view_scan_pkg.sv | 19 +
 rtl/reg_view_scan_if.sv | 26 ++
 rtl/reg_view_scan_hex_to_seg7.sv | 33 +++
 rtl/reg_view_scan.sv | 157 +++++++++++++++
 tb/tb_reg_view_scan.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_view_scan_pkg.sv
// Shared types and constants for the register-file viewer.
// State encoding, segment patterns and anode patterns live here.
package reg_view_pkg;

    typedef enum logic {
        SETTLE,
        SHOW
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [3:0] AN_OFF = 4'b1111;
    localparam logic [3:0] AN_D0  = 4'b1110;
    localparam logic [3:0] AN_D1  = 4'b1101;
    localparam logic [3:0] AN_D2  = 4'b1011;
    localparam logic [3:0] AN_D3  = 4'b0111;

endpackage

// File: rtl/reg_view_scan_if.sv
// Signal bundle between the viewer and its environment.
// The viewer takes the slave side; the board/bench takes the master side.
interface reg_view_scan_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
);

    logic              run;
    logic              step;
    logic [DATA_W-1:0] datIn;
    logic [ADDR_W-1:0] addrR;
    logic              valid;
    logic [6:0]        seg;
    logic [3:0]        an;

    modport master (
        output run, step, datIn,
        input  addrR, valid, seg, an
    );

    modport slave (
        input  run, step, datIn,
        output addrR, valid, seg, an
    );

endinterface

// File: rtl/reg_view_scan_hex_to_seg7.sv
// Nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
// Purely combinational; the caller registers the result.
module hex_to_seg7
    import reg_view_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Fixed glyph table, lower-case b and d to tell them from 8 and 0.
    always_comb begin
        seg = SEG_BLANK;
        unique case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/reg_view_scan.sv
// Sweeps register-file read port A and shows address/data on a
// 4-digit multiplexed 7-segment display.
module reg_view_scan
    import reg_view_pkg::*;
#(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 4,
    parameter int NUM_REGS       = 16,
    parameter int DWELL_CYCLES   = 50_000_000,
    parameter int REFRESH_CYCLES = 50_000
) (
    input logic            clk,
    input logic            rst,
    reg_view_scan_if.slave bus
);

    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(NUM_REGS - 1);
    localparam logic [DW-1:0]     DWELL_LAST   = DW'(DWELL_CYCLES - 1);
    localparam logic [RW-1:0]     REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

    state_t            state;
    logic [DW-1:0]     dwell;
    logic [ADDR_W-1:0] addrQ;
    logic              validQ;
    logic [DATA_W-1:0] dataQ;
    logic [RW-1:0]     refresh;
    logic [1:0]        digitIdx;
    logic [6:0]        segQ;
    logic [3:0]        anQ;

    logic       advance;
    logic [7:0] addrWide;
    logic [3:0] dataNib;
    logic [3:0] nibble;
    logic [6:0] hexSeg;
    logic [6:0] segNext;
    logic [3:0] anNext;

    // Advance only from SHOW: dwell expiry in auto-run, step pulse in manual.
    always_comb begin
        advance = 1'b0;
        if (state == SHOW) begin
            if (bus.run) begin
                advance = (dwell == DWELL_LAST);
            end else begin
                advance = bus.step;
            end
        end
    end

    // Sweep FSM: one settle cycle after each address change, then show.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= SETTLE;
            dwell  <= '0;
            addrQ  <= '0;
            validQ <= 1'b0;
            dataQ  <= '0;
        end else begin
            dataQ <= bus.datIn;
            unique case (state)
                SETTLE: begin
                    validQ <= 1'b1;
                    state  <= SHOW;
                end
                SHOW: begin
                    if (advance) begin
                        addrQ  <= (addrQ == LAST_ADDR) ? '0
                                : addrQ + ADDR_W'(1);
                        dwell  <= '0;
                        validQ <= 1'b0;
                        state  <= SETTLE;
                    end else if (bus.run) begin
                        dwell <= dwell + DW'(1);
                    end else begin
                        dwell <= '0;
                    end
                end
            endcase
        end
    end

    // Free-running digit scan, independent of the sweep FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh  <= '0;
            digitIdx <= 2'd0;
        end else if (refresh == REFRESH_LAST) begin
            refresh  <= '0;
            digitIdx <= digitIdx + 2'd1;
        end else begin
            refresh <= refresh + RW'(1);
        end
    end

    // Widen address and data so digit selection is width-independent.
    always_comb begin
        addrWide              = '0;
        addrWide[ADDR_W-1:0]  = addrQ;
        dataNib               = '0;
        dataNib[DATA_W-1:0]   = dataQ;
    end

    // Pick the nibble feeding the single shared decoder.
    always_comb begin
        nibble = dataNib;
        unique case (digitIdx)
            2'd0: nibble = dataNib;
            2'd1: nibble = 4'h0;
            2'd2: nibble = addrWide[3:0];
            2'd3: nibble = addrWide[7:4];
        endcase
    end

    hex_to_seg7 u_hex (
        .nib(nibble),
        .seg(hexSeg)
    );

    // Glyph and anode for the digit selected this cycle.
    always_comb begin
        segNext = hexSeg;
        anNext  = AN_D0;
        unique case (digitIdx)
            2'd0: begin
                anNext  = AN_D0;
                segNext = validQ ? hexSeg : SEG_DASH;
            end
            2'd1: begin
                anNext  = AN_D1;
                segNext = SEG_BLANK;
            end
            2'd2: anNext = AN_D2;
            2'd3: anNext = AN_D3;
        endcase
    end

    // seg and an share one register stage so digits never ghost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            anQ  <= AN_OFF;
            segQ <= SEG_BLANK;
        end else begin
            anQ  <= anNext;
            segQ <= segNext;
        end
    end

    assign bus.addrR = addrQ;
    assign bus.valid = validQ;
    assign bus.seg   = segQ;
    assign bus.an    = anQ;

endmodule

// File: tb/tb_reg_view_scan.sv
// Self-checking bench for reg_view_scan with a small register-file
// model, fast dwell/refresh, and directed plus random stepping.
module tb_reg_view_scan;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    reg_view_scan_if #(.ADDR_W(4), .DATA_W(4)) bus ();

    reg_view_scan #(
        .ADDR_W(4),
        .DATA_W(4),
        .NUM_REGS(16),
        .DWELL_CYCLES(8),
        .REFRESH_CYCLES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [3:0] rf [16];

    // Combinational read port of the modelled register file.
    assign bus.datIn = rf[bus.addrR];

    int nCmp  = 0;
    int nFail = 0;

    logic [6:0] hexTab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [3:0] anTab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [6:0] expSeg(input logic [3:0] an,
                                          input int addr, input int data);
        case (an)
            4'b1110: return hexTab[data % 16];
            4'b1101: return 7'b1111111;
            4'b1011: return hexTab[addr % 16];
            4'b0111: return hexTab[(addr / 16) % 16];
            default: return 7'b1111111;
        endcase
    endfunction

    // Watch one full scan and compare every digit with the expected glyph.
    task automatic checkDisplay(input string tag, input int addr);
        bit ok;
        for (int i = 0; i < 8; i++) begin
            tick();
            ok = (bus.an inside {4'b1110, 4'b1101, 4'b1011, 4'b0111});
            check({tag, "_an"}, 32'(ok), 32'd1);
            check({tag, "_seg"}, 32'(bus.seg),
                  32'(expSeg(bus.an, addr, int'(rf[addr]))));
        end
    endtask

    task automatic pulse();
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
    endtask

    // Manual stepping until the target address, bounded to one lap.
    task automatic gotoAddr(input int a);
        int k;
        k = 0;
        while (int'(bus.addrR) != a && k < 20) begin
            pulse();
            tick();
            k++;
        end
        tick(2);
        check("gotoAddr", 32'(bus.addrR), 32'(a));
    endtask

    // Auto-run from a settled address: advances land 8 edges after
    // the run edge and then every 9 edges; valid drops on those edges.
    task automatic autoRun(input string tag, input int a, input int edges);
        int n;
        bit adv;
        bus.run = 1'b1;
        for (int e = 1; e <= edges; e++) begin
            tick();
            n   = (e >= 8) ? ((e - 8) / 9 + 1) : 0;
            adv = (e >= 8) && ((e - 8) % 9 == 0);
            check({tag, "_addr"}, 32'(bus.addrR), 32'((a + n) % 16));
            check({tag, "_valid"}, 32'(bus.valid), 32'(!adv));
        end
        bus.run = 1'b0;
    endtask

    initial begin
        int  k;
        int  mAddr;
        bit  settle;
        bit  st;
        bit  acc;
        bit  stable;

        for (int i = 0; i < 16; i++) rf[i] = 4'((i + 4) % 16);
        bus.run  = 1'b0;
        bus.step = 1'b0;

        // Reset values.
        tick(2);
        check("rst_addr", 32'(bus.addrR), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_an", 32'(bus.an), 32'hF);
        check("rst_seg", 32'(bus.seg), 32'h7F);

        rst = 1'b1;
        tick();
        check("post_rst_valid", 32'(bus.valid), 32'd1);
        check("post_rst_addr", 32'(bus.addrR), 32'd0);

        // Scan order and hold time.
        k = 0;
        while (bus.an === 4'b1110 && k < 12) begin tick(); k++; end
        k = 0;
        while (bus.an !== 4'b1110 && k < 12) begin tick(); k++; end
        check("scan_sync", 32'(bus.an), 32'hE);
        for (int j = 1; j < 16; j++) begin
            tick();
            check("scan_an", 32'(bus.an), 32'(anTab[(j / 2) % 4]));
        end

        checkDisplay("addr0", 0);

        // Single manual step.
        pulse();
        check("step_addr", 32'(bus.addrR), 32'd1);
        check("step_valid0", 32'(bus.valid), 32'd0);
        tick();
        check("step_valid1", 32'(bus.valid), 32'd1);
        tick(2);
        checkDisplay("addr1", 1);

        // Step held into the settle cycle is ignored.
        bus.step = 1'b1;
        tick();
        check("settle_adv", 32'(bus.addrR), 32'd2);
        tick();
        bus.step = 1'b0;
        check("settle_ign", 32'(bus.addrR), 32'd2);
        check("settle_valid", 32'(bus.valid), 32'd1);

        // No step: address holds.
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus.addrR !== 4'd2) stable = 1'b0;
        end
        check("hold100", 32'(stable), 32'd1);

        gotoAddr(7);
        checkDisplay("addr7", 7);

        // Auto-run across the wrap, 17 advances: 7 -> 8 via 15 -> 0.
        autoRun("auto", 7, 153);

        // run 1 -> 0 mid-dwell clears dwell; re-enable restarts from 0.
        bus.run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mid_addr", 32'(bus.addrR), 32'd8);
        end
        bus.run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("freeze_addr", 32'(bus.addrR), 32'd8);
        end
        autoRun("restart", 8, 10);

        // Live write to the displayed register.
        gotoAddr(3);
        tick(3);
        rf[3] = 4'hE;
        tick(3);
        checkDisplay("live", 3);
        check("live_addr", 32'(bus.addrR), 32'd3);

        // Random contents and random manual stepping.
        for (int i = 0; i < 16; i++) rf[i] = 4'($urandom_range(0, 15));
        mAddr  = 3;
        settle = 1'b0;
        for (int c = 0; c < 300; c++) begin
            st       = ($urandom_range(0, 3) == 0);
            bus.step = st;
            tick();
            acc = st && !settle;
            if (acc) mAddr = (mAddr + 1) % 16;
            settle = acc;
            check("rnd_addr", 32'(bus.addrR), 32'(mAddr));
            check("rnd_valid", 32'(bus.valid), 32'(!acc));
        end
        bus.step = 1'b0;
        tick(3);
        checkDisplay("rnd_disp", mAddr);

        for (int r = 0; r < 3; r++) begin
            rf[mAddr] = 4'($urandom_range(0, 15));
            tick(3);
            checkDisplay("rnd_live", mAddr);
        end

        // Asynchronous reset between clock edges.
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("arst_addr", 32'(bus.addrR), 32'd0);
        check("arst_valid", 32'(bus.valid), 32'd0);
        check("arst_an", 32'(bus.an), 32'hF);
        check("arst_seg", 32'(bus.seg), 32'h7F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nFail);
        $finish;
    end

endmodule
